// File: rtl/flit_fifo_rx_if.sv
// Link bundle between an upstream output arbiter / local crossbar and one
// router input buffer. The master side drives the flit, RTS and the five
// grant-derived pops; the slave side (the buffer) answers with CTS, empty
// and the head flit. The err signal exists only when FLIT_FIFO_RX_ERR_EN
// is defined.
interface flit_fifo_rx_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] RX;
    logic                  DRTS;
    logic                  read_en_N;
    logic                  read_en_E;
    logic                  read_en_W;
    logic                  read_en_S;
    logic                  read_en_L;
    logic                  CTS;
    logic                  empty;
    logic [DATA_WIDTH-1:0] Data_out;
`ifdef FLIT_FIFO_RX_ERR_EN
    logic                  err;

    modport master (
        output RX, DRTS, read_en_N, read_en_E, read_en_W, read_en_S, read_en_L,
        input  CTS, empty, Data_out, err
    );

    modport slave (
        input  RX, DRTS, read_en_N, read_en_E, read_en_W, read_en_S, read_en_L,
        output CTS, empty, Data_out, err
    );
`else
    modport master (
        output RX, DRTS, read_en_N, read_en_E, read_en_W, read_en_S, read_en_L,
        input  CTS, empty, Data_out
    );

    modport slave (
        input  RX, DRTS, read_en_N, read_en_E, read_en_W, read_en_S, read_en_L,
        output CTS, empty, Data_out
    );
`endif
endinterface

// File: rtl/flit_fifo_rx.sv
// flit_fifo_rx: receive-side input buffer for one router port.
// Answers upstream RTS with a single-cycle CTS pulse, stores the flit in a
// circular buffer and presents the head flit combinationally. Any of the
// five output-arbiter grants pops the head.
// Optional feature: define FLIT_FIFO_RX_ERR_EN to add the sticky err output.
module flit_fifo_rx #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input logic          clk,
    input logic          rst,    // asynchronous, active-low
    flit_fifo_rx_if.slave bus
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int COUNT_W = PTR_W + 1;

    // The state bit doubles as CTS_FF: ACK is the only state with CTS high.
    typedef enum logic {
        S_IDLE = 1'b0,
        S_ACK  = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  w_wr_en;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_rd_any;
    logic                  w_pop;
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [COUNT_W-1:0]    r_count;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    assign w_full   = (r_count == COUNT_W'(DEPTH));
    assign w_empty  = (r_count == '0);
    assign w_rd_any = bus.read_en_N | bus.read_en_E | bus.read_en_W |
                      bus.read_en_S | bus.read_en_L;
    // A grant against an empty buffer is ignored.
    assign w_pop    = w_rd_any & ~w_empty;

    // Handshake next-state: accept only from IDLE, and only when a slot is free
    // before this edge (a same-cycle pop does not free it early).
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        w_state_nxt = S_IDLE;
        w_wr_en     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.DRTS && !w_full) begin
                    w_state_nxt = S_ACK;
                    w_wr_en     = 1'b1;
                end
            end
            S_ACK: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Handshake state register; reset aborts any handshake in flight.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Pointers and occupancy; a simultaneous write and pop leaves count unchanged.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr_en, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Flit storage; cleared on reset so Data_out reads zero out of reset.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: the memory is reset on purpose -- Data_out must read 0 after
        // reset -- which costs a reset net on every storage bit.
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_mem[r_wr_ptr] <= bus.RX;
        end
    end

    assign bus.CTS      = (r_state == S_ACK);
    assign bus.empty    = w_empty;
    assign bus.Data_out = r_mem[r_rd_ptr];

`ifdef FLIT_FIFO_RX_ERR_EN
    logic w_multi_rd;
    logic r_blocked;
    logic r_err;

    assign w_multi_rd = !$onehot0({bus.read_en_N, bus.read_en_E, bus.read_en_W,
                                   bus.read_en_S, bus.read_en_L});

    // Sticky protocol error: empty pop, multi-hot grant, or an RTS withdrawn
    // while it was being held off by a full buffer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_blocked <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_blocked <= (r_state == S_IDLE) && bus.DRTS && w_full;
            if ((w_rd_any && w_empty) || w_multi_rd ||
                (r_blocked && !bus.DRTS && (r_state == S_IDLE))) begin
                r_err <= 1'b1;
            end
        end
    end

    assign bus.err = r_err;
`endif

endmodule

// File: tb/tb_flit_fifo_rx.sv
// Self-checking bench for flit_fifo_rx: directed scenarios followed by random
// traffic, all checked against a queue-based reference model of the buffer.
module tb_flit_fifo_rx;

    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic clk;
    logic rst;

    flit_fifo_rx_if #(.DATA_WIDTH(DW)) bus ();

    flit_fifo_rx #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: stored flits in arrival order, CTS and err.
    logic [DW-1:0] model_q[$];
    bit            m_cts;
    bit            m_err;
    bit            m_blocked;
    bit            last_acc;
    int            n_assert;
    int            n_fail;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        model_q.delete();
        m_cts     = 1'b0;
        m_err     = 1'b0;
        m_blocked = 1'b0;
        last_acc  = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".cts"}, DW'(bus.CTS), DW'(m_cts));
        chk({tag, ".empty"}, DW'(bus.empty), DW'(model_q.size() == 0));
        if (model_q.size() > 0) begin
            chk({tag, ".data"}, bus.Data_out, model_q[0]);
        end
`ifdef FLIT_FIFO_RX_ERR_EN
        chk({tag, ".err"}, DW'(bus.err), DW'(m_err));
`endif
    endtask

    // Advance the model by one edge using the inputs as driven now, then
    // let the DUT take the same edge and compare just after it.
    task automatic tick(input string tag);
        int sz;
        int n_rd;
        bit acc;
        bit rd;
        sz   = model_q.size();
        n_rd = int'(bus.read_en_N) + int'(bus.read_en_E) + int'(bus.read_en_W) +
               int'(bus.read_en_S) + int'(bus.read_en_L);
        rd   = (n_rd != 0);
        acc  = !m_cts && bus.DRTS && (sz < DEPTH);
        if ((rd && sz == 0) || n_rd > 1 || (m_blocked && !bus.DRTS && !m_cts)) begin
            m_err = 1'b1;
        end
        m_blocked = !m_cts && bus.DRTS && (sz == DEPTH);
        if (rd && sz > 0) begin
            void'(model_q.pop_front());
        end
        if (acc) begin
            model_q.push_back(bus.RX);
        end
        m_cts    = acc;
        last_acc = acc;
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic clear_reads();
        bus.read_en_N = 1'b0;
        bus.read_en_E = 1'b0;
        bus.read_en_W = 1'b0;
        bus.read_en_S = 1'b0;
        bus.read_en_L = 1'b0;
    endtask

    initial begin
        int            cts_pulses;
        int            accepted;
        logic [DW-1:0] got[$];
        logic [DW-1:0] next_flit;

        n_assert = 0;
        n_fail   = 0;
        rst      = 1'b0;
        bus.RX   = '0;
        bus.DRTS = 1'b0;
        clear_reads();
        model_reset();

        // Reset state, visible without any clock edge.
        #2;
        chk("reset.cts", DW'(bus.CTS), '0);
        chk("reset.empty", DW'(bus.empty), DW'(1));
        chk("reset.data", bus.Data_out, '0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick("idle");
        end
        chk("idle.data", bus.Data_out, '0);

        // Single flit, then popped by the East grant.
        bus.RX   = 32'hA5A5_0001;
        bus.DRTS = 1'b1;
        tick("single.acc");
        chk("single.cts_hi", DW'(bus.CTS), DW'(1));
        chk("single.data_const", bus.Data_out, 32'hA5A5_0001);
        bus.DRTS = 1'b0;
        tick("single.ack");
        chk("single.cts_lo", DW'(bus.CTS), '0);
        bus.read_en_E = 1'b1;
        tick("single.pop");
        chk("single.empty_after_pop", DW'(bus.empty), DW'(1));
        clear_reads();

        // Fill to full with RTS held high: four accepts, then CTS stays low.
        cts_pulses = 0;
        next_flit  = 1;
        bus.RX     = next_flit;
        bus.DRTS   = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick("fill");
            if (bus.CTS) cts_pulses++;
            if (last_acc) begin
                next_flit = next_flit + 1;
                bus.RX    = next_flit;
            end
        end
        chk("fill.cts_pulses", DW'(cts_pulses), DW'(4));
        chk("fill.cts_held_low", DW'(bus.CTS), '0);
        bus.read_en_N = 1'b1;
        tick("fill.pop");
        clear_reads();
        chk("fill.head_advanced", bus.Data_out, DW'(2));
        chk("fill.no_early_cts", DW'(bus.CTS), '0);
        tick("fill.refill");
        chk("fill.cts_after_pop", DW'(bus.CTS), DW'(1));
        bus.DRTS = 1'b0;
        while (model_q.size() > 0) begin
            bus.read_en_W = 1'b1;
            tick("fill.drain");
        end
        clear_reads();

        // Stream 10 flits at full rate while the local grant pops whenever the
        // buffer holds something; pointers wrap twice.
        accepted  = 0;
        next_flit = 1;
        bus.RX    = next_flit;
        bus.DRTS  = 1'b1;
        for (int i = 0; i < 60 && (accepted < 10 || model_q.size() > 0); i++) begin
            bus.read_en_L = (model_q.size() > 0);
            if (bus.read_en_L && !bus.empty) begin
                got.push_back(bus.Data_out);
            end
            tick("wrap");
            if (last_acc) begin
                accepted++;
                next_flit = next_flit + 1;
                bus.RX    = next_flit;
                bus.DRTS  = (accepted < 10);
            end
        end
        clear_reads();
        bus.DRTS = 1'b0;
        chk("wrap.count", DW'(got.size()), DW'(10));
        for (int i = 0; i < got.size(); i++) begin
            chk($sformatf("wrap.order%0d", i), got[i], DW'(i + 1));
        end

        // Pop request against an empty buffer is ignored.
        bus.read_en_S = 1'b1;
        tick("rd_empty");
        clear_reads();
        chk("rd_empty.empty", DW'(bus.empty), DW'(1));
        tick("rd_empty.after");
`ifdef FLIT_FIFO_RX_ERR_EN
        chk("rd_empty.err_sticky", DW'(bus.err), DW'(1));
`endif
        // The buffer still works normally after the ignored pop.
        bus.RX   = 32'h0000_00C3;
        bus.DRTS = 1'b1;
        tick("rd_empty.write");
        chk("rd_empty.data", bus.Data_out, 32'h0000_00C3);
        bus.DRTS = 1'b0;
        tick("rd_empty.ack");

        // Reset during the CTS-high cycle, then re-service the held RTS.
        bus.RX   = 32'h7777_0077;
        bus.DRTS = 1'b1;
        tick("rst_hs.acc");
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        chk("rst_hs.cts", DW'(bus.CTS), '0);
        chk("rst_hs.empty", DW'(bus.empty), DW'(1));
        chk("rst_hs.data", bus.Data_out, '0);
`ifdef FLIT_FIFO_RX_ERR_EN
        chk("rst_hs.err", DW'(bus.err), '0);
`endif
        @(negedge clk);
        rst = 1'b1;
        tick("rst_hs.reacc");
        chk("rst_hs.cts_again", DW'(bus.CTS), DW'(1));
        bus.DRTS = 1'b0;
        tick("rst_hs.ack");

        // Random traffic: upstream holds RX stable until its flit is taken,
        // and at most one grant is active per cycle.
        for (int i = 0; i < 400; i++) begin
            int sel;
            clear_reads();
            sel = int'($urandom_range(0, 7));
            case (sel)
                0: bus.read_en_N = 1'b1;
                1: bus.read_en_E = 1'b1;
                2: bus.read_en_W = 1'b1;
                3: bus.read_en_S = 1'b1;
                4: bus.read_en_L = 1'b1;
                default: ;
            endcase
            if (!bus.DRTS && $urandom_range(0, 1) == 1) begin
                bus.DRTS = 1'b1;
                bus.RX   = $urandom;
            end
            tick("rand");
            if (last_acc) begin
                bus.RX   = $urandom;
                bus.DRTS = ($urandom_range(0, 1) == 1);
            end
        end
        clear_reads();
        bus.DRTS = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
